// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb_pkg
//  Brief    : Shared types and constants for the ALU share arbiter: FSM state
//             encoding, ALU op codes, response flag bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // ALU operation codes understood by the shared ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Bit positions inside the 4-bit response flag vector
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  // Place the ALU's four flag outputs at their response-vector positions
  function automatic logic [3:0] pack_flags(input logic neg, input logic zero,
                                            input logic carry, input logic ovf);
    logic [3:0] f;
    f             = '0;
    f[FLAG_NEG]   = neg;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter_if
//  Brief    : Bundle of both client request/response handshakes plus the
//             shared-ALU control/operand/result ports. The arbiter sits on
//             the slave side; clients and the ALU sit on the master side.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  // Client 0 request / response
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [2:0]       req0_op_i;
  logic [WIDTH-1:0] req0_a_i;
  logic [WIDTH-1:0] req0_b_i;
  logic             rsp0_valid_o;
  logic             rsp0_ready_i;
  logic [WIDTH-1:0] rsp0_result_o;
  logic [3:0]       rsp0_flags_o;

  // Client 1 request / response
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [2:0]       req1_op_i;
  logic [WIDTH-1:0] req1_a_i;
  logic [WIDTH-1:0] req1_b_i;
  logic             rsp1_valid_o;
  logic             rsp1_ready_i;
  logic [WIDTH-1:0] rsp1_result_o;
  logic [3:0]       rsp1_flags_o;

  // Shared ALU side
  logic [2:0]       ALUControl_o;
  logic [WIDTH-1:0] srcA_o;
  logic [WIDTH-1:0] srcB_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i;
  logic             alu_carry_i;
  logic             alu_neg_i;
  logic             alu_ovf_i;

  // Arbiter view
  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
    input  alu_result_i, alu_zero_i, alu_carry_i, alu_neg_i, alu_ovf_i,
    output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flags_o,
    output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flags_o,
    output ALUControl_o, srcA_o, srcB_o
  );

  // Client + ALU view
  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
    output alu_result_i, alu_zero_i, alu_carry_i, alu_neg_i, alu_ovf_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flags_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flags_o,
    input  ALUControl_o, srcA_o, srcB_o
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb_rr2
//  Brief    : Two-way round-robin grant. A lone valid wins outright; on a tie
//             the requester that was NOT served last wins. One-hot output,
//             all-zero when nobody is asking.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arb_rr2 (
  input  wire logic       i_valid0,
  input  wire logic       i_valid1,
  input  wire logic       i_last,
  output logic      [1:0] o_grant
);

  // Pick the winner among the two valids, breaking ties against i_last
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Brief    : Shares one combinational ALU between two clients. A granted op
//             is latched into issue registers, presented to the ALU for one
//             EXEC cycle, and the result/flags are captured into the owner's
//             response register, held until that owner acknowledges it.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  alu_share_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t       r_state;
  logic             r_last;        // requester served most recently
  logic             r_owner;       // requester owning the op in flight

  // Issue registers driving the ALU; only change on an accept
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Per-owner response registers
  logic             r_rsp0_valid;
  logic [WIDTH-1:0] r_rsp0_result;
  logic [3:0]       r_rsp0_flags;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp1_result;
  logic [3:0]       r_rsp1_flags;

  // --------------------------------------------------------------------------
  // Grant / handshake decode
  // --------------------------------------------------------------------------
  logic [1:0]       w_grant;
  logic             w_idle;
  logic             w_take0;
  logic             w_take1;
  logic             w_rsp_ack;
  logic [3:0]       w_alu_flags;

  alu_arb_rr2 u_rr2 (
    .i_valid0 (bus.req0_valid_i),
    .i_valid1 (bus.req1_valid_i),
    .i_last   (r_last),
    .o_grant  (w_grant)
  );

  // Ready is withheld while reset is asserted so nothing is accepted then
  assign w_idle  = (r_state == ST_IDLE);
  assign w_take0 = w_idle && w_grant[0] && !rst_i;
  assign w_take1 = w_idle && w_grant[1] && !rst_i;

  assign w_rsp_ack   = r_owner ? bus.rsp1_ready_i : bus.rsp0_ready_i;
  assign w_alu_flags = pack_flags(bus.alu_neg_i, bus.alu_zero_i,
                                  bus.alu_carry_i, bus.alu_ovf_i);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req0_ready_o  = w_take0;
  assign bus.req1_ready_o  = w_take1;

  assign bus.ALUControl_o  = r_op;
  assign bus.srcA_o        = r_a;
  assign bus.srcB_o        = r_b;

  assign bus.rsp0_valid_o  = r_rsp0_valid;
  assign bus.rsp0_result_o = r_rsp0_result;
  assign bus.rsp0_flags_o  = r_rsp0_flags;
  assign bus.rsp1_valid_o  = r_rsp1_valid;
  assign bus.rsp1_result_o = r_rsp1_result;
  assign bus.rsp1_flags_o  = r_rsp1_flags;

  // --------------------------------------------------------------------------
  // Sequencer: accept -> one EXEC cycle -> hold response until acknowledged
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_op          <= ALU_ADD;
      r_a           <= '0;
      r_b           <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_flags  <= '0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take0 || w_take1) begin
            // Op codes are forwarded untouched, including unused encodings
            r_op    <= w_take1 ? bus.req1_op_i : bus.req0_op_i;
            r_a     <= w_take1 ? bus.req1_a_i  : bus.req0_a_i;
            r_b     <= w_take1 ? bus.req1_b_i  : bus.req0_b_i;
            r_owner <= w_take1;
            r_last  <= w_take1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU is combinational, so its outputs are valid by this edge
          if (r_owner) begin
            r_rsp1_result <= bus.alu_result_i;
            r_rsp1_flags  <= w_alu_flags;
            r_rsp1_valid  <= 1'b1;
          end else begin
            r_rsp0_result <= bus.alu_result_i;
            r_rsp0_flags  <= w_alu_flags;
            r_rsp0_valid  <= 1'b1;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          // The IDLE cycle that follows is the earliest new accept
          if (w_rsp_ack) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Brief    : Self-checking bench for alu_share_arbiter with a behavioural
//             ALU beside it and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {neg, zero, carry, ovf, result}
  function automatic logic [W+3:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = ~(a & b);
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  logic [W+3:0] w_alu;
  assign w_alu            = alu_fn(bus.ALUControl_o, bus.srcA_o, bus.srcB_o);
  assign bus.alu_result_i = w_alu[W-1:0];
  assign bus.alu_ovf_i    = w_alu[W];
  assign bus.alu_carry_i  = w_alu[W+1];
  assign bus.alu_zero_i   = w_alu[W+2];
  assign bus.alu_neg_i    = w_alu[W+3];

  // Single comparison point
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction in flight, tracked by age in cycles
  bit           m_pend;
  int           m_age;
  int           m_own;
  bit           m_last;
  logic [2:0]   m_iop;
  logic [W-1:0] m_ia;
  logic [W-1:0] m_ib;
  logic [W-1:0] m_res;
  logic [3:0]   m_flg;
  int           grant_log[$];

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model
  task automatic run_cycle(input bit v0, input bit v1,
                           input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input bit rr0, input bit rr1);
    int           g;
    logic [W+3:0] t;
    @(negedge clk);
    if (m_pend) m_age++;
    chk("rsp0_valid", bus.rsp0_valid_o, m_pend && m_age >= 2 && m_own == 0);
    chk("rsp1_valid", bus.rsp1_valid_o, m_pend && m_age >= 2 && m_own == 1);
    if (m_pend && m_age >= 2 && m_own == 0) begin
      chk("rsp0_result", bus.rsp0_result_o, m_res);
      chk("rsp0_flags", bus.rsp0_flags_o, m_flg);
    end
    if (m_pend && m_age >= 2 && m_own == 1) begin
      chk("rsp1_result", bus.rsp1_result_o, m_res);
      chk("rsp1_flags", bus.rsp1_flags_o, m_flg);
    end
    chk("alu_ctl", bus.ALUControl_o, m_iop);
    chk("alu_srcA", bus.srcA_o, m_ia);
    chk("alu_srcB", bus.srcB_o, m_ib);

    bus.req0_valid_i = v0;  bus.req0_op_i = op0;  bus.req0_a_i = a0;  bus.req0_b_i = b0;
    bus.req1_valid_i = v1;  bus.req1_op_i = op1;  bus.req1_a_i = a1;  bus.req1_b_i = b1;
    bus.rsp0_ready_i = rr0; bus.rsp1_ready_i = rr1;
    #1;

    g = -1;
    if (!m_pend) begin
      if (v0 && v1) g = m_last ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("req0_ready", bus.req0_ready_o, g == 0);
    chk("req1_ready", bus.req1_ready_o, g == 1);

    if (g >= 0) begin
      m_pend = 1'b1;
      m_age  = 0;
      m_own  = g;
      m_last = (g == 1);
      m_iop  = (g == 1) ? op1 : op0;
      m_ia   = (g == 1) ? a1  : a0;
      m_ib   = (g == 1) ? b1  : b0;
      t      = alu_fn(m_iop, m_ia, m_ib);
      m_res  = t[W-1:0];
      m_flg  = t[W+3:W];
      grant_log.push_back(g);
    end else if (m_pend && m_age >= 2 && ((m_own == 1) ? rr1 : rr0)) begin
      m_pend = 1'b0;
    end
  endtask

  // Hold reset for a number of edges with both requests asserted; checks reset state
  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    chk("rst_req0_ready", bus.req0_ready_o, 0);
    chk("rst_req1_ready", bus.req1_ready_o, 0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp0_valid", bus.rsp0_valid_o, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid_o, 0);
    chk("rst_alu_ctl", bus.ALUControl_o, 0);
    chk("rst_srcA", bus.srcA_o, 0);
    chk("rst_srcB", bus.srcB_o, 0);
    chk("rst_ready_hold", {bus.req0_ready_o, bus.req1_ready_o}, 0);
    rst = 1'b0;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    m_pend = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
    m_iop  = '0;
    m_ia   = '0;
    m_ib   = '0;
  endtask

  localparam logic [W-1:0] OPA = 32'h0123_4567;
  localparam logic [W-1:0] OPB = 32'h1111_1111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   rop0, rop1;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req0_valid_i = 0; bus.req0_op_i = 0; bus.req0_a_i = 0; bus.req0_b_i = 0;
    bus.req1_valid_i = 0; bus.req1_op_i = 0; bus.req1_a_i = 0; bus.req1_b_i = 0;
    bus.rsp0_ready_i = 0; bus.rsp1_ready_i = 0;
    m_pend = 0; m_age = 0; m_own = 0; m_last = 1;
    m_iop = 0; m_ia = 0; m_ib = 0; m_res = 0; m_flg = 0;
    pulse_reset(2);

    // Contention right after reset: xor from req0, or from req1, both held valid
    grant_log.delete();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1, 1, ALU_XOR, OPA, OPB, ALU_OR, OPA, OPB, 1, 1);
      if (i == 2) chk("cont_xor_result", bus.rsp0_result_o, 32'h1032_5476);
      if (i == 5) chk("cont_or_result", bus.rsp1_result_o, 32'h1133_5577);
    end
    chk("cont_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) chk("cont_grant_alt", grant_log[i], i % 2);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // req0 add
    run_cycle(1, 0, ALU_ADD, OPA, OPB, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("add_result", bus.rsp0_result_o, 32'h1234_5678);
    chk("add_neg", bus.rsp0_flags_o[FLAG_NEG], 0);
    chk("add_zero", bus.rsp0_flags_o[FLAG_ZERO], 0);
    chk("add_ovf", bus.rsp0_flags_o[FLAG_OVF], 0);

    // req1 sub
    run_cycle(0, 1, 0, 0, 0, ALU_SUB, OPA, OPB, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sub_result", bus.rsp1_result_o, 32'hF012_3456);
    chk("sub_neg", bus.rsp1_flags_o[FLAG_NEG], 1);
    chk("sub_zero", bus.rsp1_flags_o[FLAG_ZERO], 0);
    chk("sub_rsp0_quiet", bus.rsp0_valid_o, 0);

    // Zero flag
    run_cycle(1, 0, ALU_SUB, OPA, OPA, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("zero_result", bus.rsp0_result_o, 0);
    chk("zero_flag", bus.rsp0_flags_o[FLAG_ZERO], 1);
    chk("zero_neg", bus.rsp0_flags_o[FLAG_NEG], 0);

    // Backpressure on rsp0 for 5 RESP cycles with both requests pending
    run_cycle(1, 0, ALU_ADD, OPA, OPB, ALU_XOR, OPB, OPA, 0, 0);
    run_cycle(1, 1, ALU_ADD, OPA, OPB, ALU_XOR, OPB, OPA, 0, 0);
    for (int i = 0; i < 5; i++) run_cycle(1, 1, ALU_ADD, OPA, OPB, ALU_XOR, OPB, OPA, 0, 0);
    chk("bp_hold_result", bus.rsp0_result_o, 32'h1234_5678);
    run_cycle(1, 1, ALU_ADD, OPA, OPB, ALU_XOR, OPB, OPA, 1, 0);
    run_cycle(1, 1, ALU_ADD, OPA, OPB, ALU_XOR, OPB, OPA, 0, 0);
    chk("bp_next_accept", bus.req1_ready_o, 1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset during EXEC of a req0 op; req0 must still win the next tie
    run_cycle(1, 0, ALU_OR, OPA, OPB, 0, 0, 0, 0, 0);
    pulse_reset(1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    run_cycle(1, 1, ALU_AND, OPA, OPB, ALU_ADD, OPB, OPB, 1, 1);
    chk("tie_after_rst", bus.req0_ready_o, 1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Randomized traffic, including unused op codes and occasional resets
    for (int i = 0; i < 400; i++) begin
      rop0 = 3'($urandom_range(0, 7));
      rop1 = 3'($urandom_range(0, 7));
      ra0 = $urandom; rb0 = ($urandom_range(0, 7) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(0, 7) == 0) ? ra1 : $urandom;
      if ($urandom_range(0, 59) == 0) pulse_reset(1);
      run_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                rop0, ra0, rb0, rop1, ra1, rb1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the single shared `ALU` in the RV32I datapath. It accepts operations (op code, operand A/B) from two clients over valid/ready handshakes and grants the ALU round-robin. It drives the ALU's control and operand ports from internal issue registers, then captures `result_o` and the four flags into a per-owner response register. That response is held until the owning client acknowledges it.

## Interface
- `WIDTH`, default 32: datapath width, equal to the ALU's width parameter.
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `reqN_valid_i`  in  1  (N = 0, 1) operation request.
- `reqN_ready_o`  out  1  request accepted this cycle when high together with valid.
- `reqN_op_i`  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor.
- `reqN_a_i`, `reqN_b_i`  in  WIDTH  operands.
- `rspN_valid_o`  out  1  response available for requester N.
- `rspN_ready_i`  in  1  requester N consumes the response.
- `rspN_result_o`  out  WIDTH  captured ALU result.
- `rspN_flags_o`  out  4  {negative, zero, carry, overflow}.
- `ALUControl_o`  out  3  to ALU `ALUControl_i`.
- `srcA_o`, `srcB_o`  out  WIDTH  to ALU `srcA_i` / `srcB_i`.
- `alu_result_i`  in  WIDTH  from ALU `result_o`.
- `alu_zero_i`, `alu_carry_i`, `alu_neg_i`, `alu_ovf_i`  in  1 each  from the ALU flag outputs.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- Grant (combinational, IDLE only):
  - If only one valid is high, that requester is granted.
  - If both are high, the requester not in `last_q` is granted.
  - `reqN_ready_o` = (state == IDLE) && grant == N && !rst_i. At most one ready is high per cycle.
- IDLE → EXEC on the accept handshake. That edge latches op/a/b into the issue registers, sets owner_q = N and last_q = N.
- EXEC:
  - `ALUControl_o`/`srcA_o`/`srcB_o` present the issue registers. The ALU responds combinationally within the same cycle.
  - At the edge ending EXEC, `alu_result_i` and the flags are registered into the response register. `rspN_valid_o` for owner_q is set, and the FSM moves to RESP.
- RESP: the response is held stable until `rsp<owner>_ready_i` is high, then the FSM returns to IDLE. No new request is accepted in EXEC or RESP.
- Op codes 101–111 are passed to the ALU unchanged. The arbiter neither checks nor alters them.
- Only the owner's `rspN_valid_o` is ever high. The other requester's `rspN_result_o`/`rspN_flags_o` are don't-care but stable.
- Reset values:
  - state IDLE, last_q = 1 (req0 wins the first tie), owner_q = 0.
  - Issue and response registers 0, so `ALUControl_o` = 000 and `srcA_o` = `srcB_o` = 0.
  - Both `rspN_valid_o` = 0, both `reqN_ready_o` = 0.
- Reset mid-operation (EXEC or RESP): the pending op is discarded and no response is produced. The FSM restarts in IDLE on the cycle after `rst_i` falls.
- A request held in the same cycle that `rsp` is consumed is not accepted until the following IDLE cycle.

## Timing
- Accept at edge E0 (cycle 0 handshake).
- EXEC occupies cycle 1.
- `rspN_valid_o` is high from cycle 2.
- If `rspN_ready_i` is high in cycle 2, IDLE is reached in cycle 3, which is the earliest next accept.
- Minimum latency is 2 cycles, request to response. Peak throughput is one op per 3 cycles.
- `reqN_ready_o` is combinational from state, the two valids and last_q. It has no dependence on `reqN_op/a/b`.
- ALU input ports change only at the IDLE→EXEC edge. They are stable for all of EXEC and RESP.

## Structure
- Package `alu_arb_pkg` holds:
  - state enum (IDLE/EXEC/RESP);
  - ALU op constants ALU_ADD = 000, ALU_SUB = 001, ALU_AND = 010, ALU_OR = 011, ALU_XOR = 100;
  - flag bit indices FLAG_NEG = 3, FLAG_ZERO = 2, FLAG_CARRY = 1, FLAG_OVF = 0.
- One sub-module is natural: `alu_arb_rr2`, the 2-way round-robin grant taking the two valids and last_q and returning a one-hot grant.
- The ALU itself is instantiated beside the arbiter by the parent, not inside it. The test bench instantiates both.

## Test plan
- **req0 add:** A = 0x01234567, B = 0x11111111, op 000 → `rsp0_valid_o` in cycle 2, result 0x12345678, flags negative = 0, zero = 0, overflow = 0, carry = ALU value.
- **req1 sub:** 0x01234567 − 0x11111111 → result 0xF0123456, negative = 1, zero = 0. `rsp0_valid_o` stays 0 throughout.
- **Contention:** both requesters valid in the first cycle after reset, req0 = xor 0x01234567 / 0x11111111, req1 = or of the same operands:
  - req0 is served first → 0x10325476;
  - req1 is served next → 0x11335577;
  - with both held valid, grants alternate 0, 1, 0, 1.
- **Backpressure:** `rsp0_ready_i` held low for 5 cycles → result, flags and `ALUControl_o`/`srcA_o`/`srcB_o` are stable. Both `reqN_ready_o` stay 0. The next accept happens exactly 1 cycle after `rsp0_ready_i` rises.
- **Zero flag:** sub with A = B = 0x01234567 → result 0, zero = 1, negative = 0.
- **Reset during EXEC:** `rst_i` pulsed for 1 cycle → no `rspN_valid_o` appears. All outputs return to reset values. The next tie is granted to req0.
